eq_preset_loader: RTL and testbench
===================================

# eq_preset_loader

Bus master that programs the 12-band equalizer gain registers from a built-in preset table, then optionally reads every register back and checks it. Sits on the `system_clk` control bus in front of the equalizer's register slave. It replaces 12 individual host writes with a single start pulse and reports busy, done and verify-error status.

## Interface
Parameters:
- NUM_BANDS, 12, number of band registers written; addresses 0..NUM_BANDS-1.
- UNITY, 5'd13, gain code meaning 0 dB (no shift).

Ports:
- system_clk  in  1  clock; everything in this block runs on it.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- preset_sel  in  2  preset index; latched with start.
- verify_en  in  1  1 = read-back check after writes; latched with start.
- busy  out  1  high from the first bus cycle through the last bus cycle.
- done  out  1  one-cycle pulse when the sequence ends (pass or fail).
- error  out  1  sticky verify failure; cleared by the next accepted start or by reset.
- err_band  out  4  index of the first mismatching band; valid while error=1.
- address  out  4  bus address (band index).
- writedata  out  8  {3'b000, gain[4:0]}.
- readdata  in  8  slave read data; registered by the slave on the edge ending the read cycle.
- chipselect  out  1  bus select.
- write  out  1  write strobe.
- read  out  1  read strobe.

## Operation
- Preset table is constant, 5-bit codes, band 0 = 31 Hz … band 11 = 20 kHz:
  - 0 flat: all 13.
  - 1 bass: bands 0-3 = 15; bands 4-5 = 14; bands 6-11 = 13.
  - 2 treble: bands 0-7 = 13; bands 8-9 = 14; bands 10-11 = 15.
  - 3 mute: all 0.
- FSM states: IDLE → WRITE → (RD_REQ ↔ RD_CHK) → FINISH → IDLE.
- IDLE:
  - All bus strobes are 0.
  - When start=1, latch preset_sel and verify_en, clear error and err_band, set the band counter to 0, and go to WRITE.
- WRITE, one cycle per band:
  - Drive chipselect=1, write=1, address=band, writedata={3'b0, table[preset][band]}.
  - Increment band each cycle.
  - After band NUM_BANDS-1: if verify_en=1, reset band to 0 and go to RD_REQ; otherwise go to FINISH.
- RD_REQ: drive chipselect=1, read=1, address=band; go to RD_CHK.
- RD_CHK:
  - Strobes are 0; compare readdata with {3'b0, table[preset][band]}.
  - On mismatch: set error=1, err_band=band, go to FINISH. Remaining bands are not checked.
  - On match: if band = NUM_BANDS-1, go to FINISH; otherwise increment band and go to RD_REQ.
- FINISH: busy=0, done=1 for this cycle only; go to IDLE.
- Width rules:
  - address is the 4-bit band counter.
  - The full 8 bits of readdata are compared, so nonzero readdata[7:5] counts as a mismatch.
- A start asserted in any state other than IDLE is ignored; no queuing.
- preset_sel and verify_en changes after the start cycle have no effect on the running sequence.

## Timing
- All outputs are registered. Let cycle 0 be the cycle in which start is sampled high in IDLE.
- Write phase:
  - Writes to band k occupy cycle 1+k (cycles 1..12).
  - busy=1 from cycle 1.
- Verify disabled: done=1 and busy=0 in cycle 13.
- Verify enabled:
  - RD_REQ for band k is in cycle 13+2k.
  - The check of band k is in cycle 14+2k.
  - Full pass: done in cycle 37, with busy=1 through cycle 36.
  - Failure on band k: done in cycle 15+2k. error and err_band become visible in that same cycle and hold until the next accepted start.
- Strobes:
  - write and read are never high together.
  - chipselect=1 exactly when write or read is 1.
- Reset values: busy, done, error, chipselect, write, read = 0; address, writedata, err_band = 0; state IDLE.
- Reset mid-sequence: all outputs return to reset values on the next edge and no further bus cycles are issued. Registers already written keep their values.
- start and reset asserted together: reset wins and start is dropped.

## Test plan
- Flat preset, verify_en=1, model slave at initial value 13:
  - 12 writes of 0x0D to addresses 0..11 in cycles 1-12.
  - 12 reads; done at cycle 37 with error=0.
- Bass preset, verify_en=0:
  - Writedata per address is 0F,0F,0F,0F,0E,0E,0D×6.
  - No read strobes; done at cycle 13.
- Treble preset with the slave corrupting address 9 (returns 0x0D):
  - error=1, err_band=9, done at cycle 33.
  - No read issued to addresses 10 or 11.
- Slave returning 0x20 on address 0 under the mute preset:
  - error=1, err_band=0, done at cycle 15.
- start pulsed again at cycle 5 of a running sequence:
  - Ignored; the sequence completes unchanged.
  - A subsequent start after done clears error.
- reset asserted at cycle 7:
  - All strobes are 0 at cycle 8 and busy=0.
  - Addresses 0-5 hold the new values; address 6 onward is unchanged.

Source files
------------

// File: rtl/eq_preset_loader.sv
// Programs the 12 equalizer band gain registers from a fixed preset table over the
// control bus, then optionally reads each one back and flags the first mismatch.
module eq_preset_loader #(
  parameter int         NUM_BANDS = 12,
  parameter logic [4:0] UNITY     = 5'd13
) (
  input  logic       system_clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] preset_sel,
  input  logic       verify_en,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] err_band,
  output logic [3:0] address,
  output logic [7:0] writedata,
  input  logic [7:0] readdata,
  output logic       chipselect,
  output logic       write,
  output logic       read
);

  typedef enum logic [2:0] {IDLE, WRITE, RD_REQ, RD_CHK, FINISH} state_t;

  localparam logic [3:0] LAST_BAND = 4'(NUM_BANDS - 1);

  state_t     state;
  logic [1:0] preset_q;
  logic       verify_q;
  logic [3:0] band;

  // Gain code for one band of one preset; band 0 is the lowest frequency.
  function automatic logic [4:0] preset_gain(input logic [1:0] sel, input logic [3:0] b);
    logic [4:0] g;
    g = UNITY;
    case (sel)
      2'd1: begin
        if (b <= 4'd3)      g = UNITY + 5'd2;
        else if (b <= 4'd5) g = UNITY + 5'd1;
      end
      2'd2: begin
        if (b >= 4'd10)     g = UNITY + 5'd2;
        else if (b >= 4'd8) g = UNITY + 5'd1;
      end
      2'd3:    g = 5'd0;
      default: g = UNITY;
    endcase
    return g;
  endfunction

  function automatic logic [7:0] bus_word(input logic [1:0] sel, input logic [3:0] b);
    return {3'b000, preset_gain(sel, b)};
  endfunction

  // Outputs are registered: each transition loads the bus values of the state entered.
  always_ff @(posedge system_clk) begin
    if (reset) begin
      state      <= IDLE;
      preset_q   <= 2'd0;
      verify_q   <= 1'b0;
      band       <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_band   <= 4'd0;
      address    <= 4'd0;
      writedata  <= 8'd0;
      chipselect <= 1'b0;
      write      <= 1'b0;
      read       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            preset_q   <= preset_sel;
            verify_q   <= verify_en;
            error      <= 1'b0;
            err_band   <= 4'd0;
            band       <= 4'd0;
            state      <= WRITE;
            busy       <= 1'b1;
            chipselect <= 1'b1;
            write      <= 1'b1;
            address    <= 4'd0;
            writedata  <= bus_word(preset_sel, 4'd0);
          end
        end
        WRITE: begin
          if (band == LAST_BAND) begin
            write <= 1'b0;
            if (verify_q) begin
              band    <= 4'd0;
              address <= 4'd0;
              read    <= 1'b1;
              state   <= RD_REQ;
            end else begin
              chipselect <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              state      <= FINISH;
            end
          end else begin
            band      <= band + 4'd1;
            address   <= band + 4'd1;
            writedata <= bus_word(preset_q, band + 4'd1);
          end
        end
        RD_REQ: begin
          chipselect <= 1'b0;
          read       <= 1'b0;
          state      <= RD_CHK;
        end
        // readdata was captured by the slave at the edge that closed the read cycle.
        RD_CHK: begin
          if (readdata != bus_word(preset_q, band)) begin
            error    <= 1'b1;
            err_band <= band;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= FINISH;
          end else if (band == LAST_BAND) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FINISH;
          end else begin
            band       <= band + 4'd1;
            address    <= band + 4'd1;
            chipselect <= 1'b1;
            read       <= 1'b1;
            state      <= RD_REQ;
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eq_preset_loader.sv
// Randomized bench for eq_preset_loader: a register-slave model on the bus and a
// per-cycle expected trace derived from the preset table and sequence timing.
module tb_eq_preset_loader;

  logic       system_clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] preset_sel;
  logic       verify_en;
  logic       busy, done, error;
  logic [3:0] err_band, address;
  logic [7:0] writedata, readdata;
  logic       chipselect, write, read;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave model; shares the bus reset, so it accepts no bus cycle while reset is high.
  logic [7:0] slave_regs [16];
  logic [7:0] init_vals  [16];
  logic       init_pulse;
  logic       corrupt_en;
  logic [3:0] corrupt_addr;
  logic [7:0] corrupt_val;

  eq_preset_loader dut (
    .system_clk (system_clk),
    .reset      (reset),
    .start      (start),
    .preset_sel (preset_sel),
    .verify_en  (verify_en),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_band   (err_band),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .chipselect (chipselect),
    .write      (write),
    .read       (read)
  );

  always #5 system_clk = ~system_clk;

  always @(posedge system_clk) begin
    if (init_pulse) begin
      for (int i = 0; i < 16; i++) slave_regs[i] <= init_vals[i];
      readdata <= 8'd0;
    end else if (!reset && chipselect) begin
      if (write) slave_regs[address] <= writedata;
      if (read)  readdata <= (corrupt_en && address == corrupt_addr) ? corrupt_val
                                                                     : slave_regs[address];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_gain(input int p, input int b);
    case (p)
      0:       return 8'h0D;
      1:       return (b < 4) ? 8'h0F : (b < 6) ? 8'h0E : 8'h0D;
      2:       return (b < 8) ? 8'h0D : (b < 10) ? 8'h0E : 8'h0F;
      default: return 8'h00;
    endcase
  endfunction

  // One full start sequence; restart_c/reset_c = cycle in which start/reset is high (0 = none).
  task automatic run_seq(input int p, input bit v, input int restart_c, input int reset_c,
                         input bit cen, input int caddr, input logic [7:0] cval);
    logic [7:0] exp_regs [16];
    logic [7:0] rv;
    bit         fail;
    int         last_k, done_c, end_c, eaddr;
    bit         ecs, ewr, erd, ebusy, edone, eerr;

    @(posedge system_clk); #1;
    for (int i = 0; i < 16; i++) begin
      init_vals[i] = 8'($urandom);
      exp_regs[i]  = init_vals[i];
    end
    corrupt_en   = cen;
    corrupt_addr = 4'(caddr);
    corrupt_val  = cval;
    init_pulse   = 1'b1;
    @(posedge system_clk); #1;
    init_pulse = 1'b0;

    for (int k = 0; k < 12; k++)
      if (reset_c == 0 || k < reset_c - 1) exp_regs[k] = ref_gain(p, k);
    fail   = 1'b0;
    last_k = 11;
    if (v) begin
      for (int k = 0; k < 12; k++) begin
        rv = (cen && k == caddr) ? cval : ref_gain(p, k);
        if (rv != ref_gain(p, k)) begin
          fail   = 1'b1;
          last_k = k;
          break;
        end
      end
    end
    done_c = !v ? 13 : (fail ? 15 + 2 * last_k : 37);
    end_c  = (reset_c != 0) ? reset_c + 3 : done_c + 1;

    // cycle 0
    start      = 1'b1;
    preset_sel = 2'(p);
    verify_en  = v;
    for (int c = 1; c <= end_c; c++) begin
      @(posedge system_clk); #1;
      start      = (c == restart_c);
      reset      = (c == reset_c);
      preset_sel = 2'($urandom);
      verify_en  = 1'($urandom);
      @(negedge system_clk);
      {ecs, ewr, erd, ebusy, edone, eerr} = 6'b0;
      eaddr = 0;
      if (reset_c != 0 && c > reset_c) begin
        chk($sformatf("rst_addr c%0d", c), 32'(address), 32'd0);
        chk($sformatf("rst_wdata c%0d", c), 32'(writedata), 32'd0);
        chk($sformatf("rst_errband c%0d", c), 32'(err_band), 32'd0);
      end else if (c <= 12) begin
        {ecs, ewr, ebusy} = 3'b111;
        eaddr = c - 1;
      end else if (c < done_c) begin
        ebusy = 1'b1;
        if ((c - 13) % 2 == 0) begin
          {ecs, erd} = 2'b11;
          eaddr = (c - 13) / 2;
        end
      end else begin
        edone = (c == done_c);
        eerr  = fail;
      end
      chk($sformatf("ctl{cs,wr,rd,busy,done,err} p%0d v%0d c%0d", p, v, c),
          32'({chipselect, write, read, busy, done, error}),
          32'({ecs, ewr, erd, ebusy, edone, eerr}));
      if (ecs) chk($sformatf("addr c%0d", c), 32'(address), 32'(eaddr));
      if (ewr) chk($sformatf("wdata p%0d c%0d", p, c), 32'(writedata), 32'(ref_gain(p, eaddr)));
      if (eerr) chk($sformatf("err_band c%0d", c), 32'(err_band), 32'(last_k));
    end
    start = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 12; i++)
      chk($sformatf("slave_reg%0d p%0d", i, p), 32'(slave_regs[i]), 32'(exp_regs[i]));
  endtask

  initial begin
    int p, rs, rr, ca;
    bit v, ce;
    logic [7:0] cv;

    reset      = 1'b1;
    start      = 1'b0;
    preset_sel = 2'd0;
    verify_en  = 1'b0;
    init_pulse = 1'b0;
    corrupt_en = 1'b0;
    corrupt_addr = 4'd0;
    corrupt_val  = 8'd0;
    for (int i = 0; i < 16; i++) init_vals[i] = 8'h0D;
    repeat (2) @(posedge system_clk);
    @(negedge system_clk);
    chk("reset_ctl", 32'({chipselect, write, read, busy, done, error}), 32'd0);
    chk("reset_addr", 32'(address), 32'd0);
    chk("reset_wdata", 32'(writedata), 32'd0);
    chk("reset_errband", 32'(err_band), 32'd0);
    reset = 1'b0;

    run_seq(0, 1'b1, 0, 0, 1'b0, 0, 8'h00);   // flat, full verify pass
    run_seq(1, 1'b0, 0, 0, 1'b0, 0, 8'h00);   // bass, no verify
    run_seq(2, 1'b1, 0, 0, 1'b1, 9, 8'h0D);   // treble, band 9 corrupted
    run_seq(3, 1'b1, 0, 0, 1'b1, 0, 8'h20);   // mute, upper bits set on band 0
    run_seq(2, 1'b1, 5, 0, 1'b1, 3, 8'h00);   // ignored restart, fails at band 3
    run_seq(0, 1'b1, 0, 0, 1'b0, 0, 8'h00);   // next start clears error
    run_seq(1, 1'b1, 0, 7, 1'b0, 0, 8'h00);   // reset mid-write

    // start and reset together from IDLE
    @(posedge system_clk); #1;
    start = 1'b1;
    reset = 1'b1;
    @(posedge system_clk); #1;
    start = 1'b0;
    reset = 1'b0;
    @(negedge system_clk);
    chk("start_reset_ctl", 32'({chipselect, write, read, busy, done, error}), 32'd0);
    @(negedge system_clk);
    chk("start_reset_idle", 32'({chipselect, write, busy}), 32'd0);

    for (int n = 0; n < 12; n++) begin
      p  = $urandom_range(0, 3);
      v  = 1'($urandom);
      ce = 1'($urandom);
      ca = $urandom_range(0, 11);
      cv = ($urandom_range(0, 1) == 1) ? (ref_gain(p, ca) ^ (8'h01 << $urandom_range(0, 7)))
                                       : 8'($urandom);
      rr = ($urandom_range(0, 4) == 0) ? $urandom_range(2, 12) : 0;
      rs = (rr == 0 && $urandom_range(0, 1) == 1) ? $urandom_range(1, 12) : 0;
      run_seq(p, v, rs, rr, ce, ca, cv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
